// File: rtl/router_out_sched_if.sv
// Bundle of the FIFO-side and egress-link signals of the router output scheduler.
//   master : scheduler view (reads FIFO status/data, drives read strobes and the link)
//   slave  : FIFO/link view (drives FIFO status/data and link_ready, observes the rest)
// CNT_W must match the scheduler's CNT_W parameter.
interface router_out_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             vld_out_0, vld_out_1, vld_out_2;
  logic             soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0]       dout_0, dout_1, dout_2;
  logic             link_ready;
  logic             read_enb_0, read_enb_1, read_enb_2;
  logic [7:0]       link_data;
  logic             link_valid, link_sop, link_eop, link_abort;
  logic [1:0]       grant;
  logic [CNT_W-1:0] pkt_cnt_0, pkt_cnt_1, pkt_cnt_2;

  modport master (
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  dout_0, dout_1, dout_2,
    input  link_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output link_data, link_valid, link_sop, link_eop, link_abort,
    output grant,
    output pkt_cnt_0, pkt_cnt_1, pkt_cnt_2
  );

  modport slave (
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output dout_0, dout_1, dout_2,
    output link_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  link_data, link_valid, link_sop, link_eop, link_abort,
    input  grant,
    input  pkt_cnt_0, pkt_cnt_1, pkt_cnt_2
  );
endinterface

// File: rtl/router_out_sched.sv
// Packet-level round-robin read scheduler for the three router output FIFOs.
// Grants one FIFO at a time, reads header, payload and parity, and forwards the bytes onto
// one shared egress link with sop/eop markers; a soft reset of the granted FIFO truncates the
// packet with a one-cycle link_abort.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : router_out_sched_if.master (FIFO status/data in, read strobes, link, grant, counters)
// Optional feature: define ROUTER_SCHED_STATS_EN to build the saturating per-port packet
// counters; otherwise pkt_cnt_x are tied to zero.
module router_out_sched #(
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                resetn,
  router_out_sched_if.master bus
);

  typedef enum logic [2:0] {StIdle, StHread, StHcap, StBody, StDrain} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [6:0] left_q, left_d;
  logic       link_valid_q, link_valid_d;
  logic       link_sop_q, link_sop_d;
  logic       link_eop_q, link_eop_d;
  logic       link_abort_q, link_abort_d;

  logic [2:0] vld;
  logic       vld_g, srst_g, can_read, rd_issue;
  logic [7:0] dout_g;
  logic [1:0] pick, grant_inc;

  assign vld       = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
  assign grant_inc = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;

  // Signals of the granted port; grant 3 (idle) selects nothing.
  always_comb begin
    vld_g  = 1'b0;
    srst_g = 1'b0;
    dout_g = 8'h00;
    unique case (grant_q)
      2'd0: begin vld_g = bus.vld_out_0; srst_g = bus.soft_reset_0; dout_g = bus.dout_0; end
      2'd1: begin vld_g = bus.vld_out_1; srst_g = bus.soft_reset_1; dout_g = bus.dout_1; end
      2'd2: begin vld_g = bus.vld_out_2; srst_g = bus.soft_reset_2; dout_g = bus.dout_2; end
      default: ;
    endcase
  end

  // First requester at or after rr_ptr; only meaningful when some vld_out is set.
  always_comb begin
    pick = 2'd0;
    case (rr_ptr_q)
      2'd1:    pick = vld[1] ? 2'd1 : (vld[2] ? 2'd2 : 2'd0);
      2'd2:    pick = vld[2] ? 2'd2 : (vld[0] ? 2'd0 : 2'd1);
      default: pick = vld[0] ? 2'd0 : (vld[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign can_read = vld_g && bus.link_ready && !srst_g;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    left_d       = left_q;
    rd_issue     = 1'b0;
    link_sop_d   = 1'b0;
    link_eop_d   = 1'b0;
    link_abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|vld) begin
          grant_d = pick;
          state_d = StHread;
        end
      end
      StHread: begin
        if (can_read) begin
          rd_issue   = 1'b1;
          link_sop_d = 1'b1;
          state_d    = StHcap;
        end
      end
      StHcap: begin
        // Header is on dout now: payload bytes plus the parity byte remain.
        left_d  = {1'b0, dout_g[7:2]} + 7'd1;
        state_d = StBody;
      end
      StBody: begin
        if (can_read) begin
          rd_issue = 1'b1;
          left_d   = left_q - 7'd1;
          if (left_q == 7'd1) begin
            link_eop_d = 1'b1;
            state_d    = StDrain;
          end
        end
      end
      StDrain: begin
        rr_ptr_d = grant_inc;
        grant_d  = 2'd3;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush of the granted FIFO overrides everything: truncate and move on.
    if (state_q != StIdle && srst_g) begin
      link_eop_d   = 1'b0;
      link_abort_d = 1'b1;
      rr_ptr_d     = grant_inc;
      grant_d      = 2'd3;
      left_d       = 7'd0;
      state_d      = StIdle;
    end
  end

  assign link_valid_d = rd_issue;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_q      <= 2'd3;
      rr_ptr_q     <= 2'd0;
      left_q       <= 7'd0;
      link_valid_q <= 1'b0;
      link_sop_q   <= 1'b0;
      link_eop_q   <= 1'b0;
      link_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      left_q       <= left_d;
      link_valid_q <= link_valid_d;
      link_sop_q   <= link_sop_d;
      link_eop_q   <= link_eop_d;
      link_abort_q <= link_abort_d;
    end
  end

  assign bus.read_enb_0 = rd_issue && (grant_q == 2'd0);
  assign bus.read_enb_1 = rd_issue && (grant_q == 2'd1);
  assign bus.read_enb_2 = rd_issue && (grant_q == 2'd2);

  // FIFO dout is itself a register loaded by read_enb, so the byte is forwarded in the cycle
  // after the read; grant is still held in that cycle (HCAP, BODY or DRAIN).
  assign bus.link_data  = link_valid_q ? dout_g : 8'h00;
  assign bus.link_valid = link_valid_q;
  assign bus.link_sop   = link_sop_q;
  assign bus.link_eop   = link_eop_q;
  assign bus.link_abort = link_abort_q;
  assign bus.grant      = grant_q;

`ifdef ROUTER_SCHED_STATS_EN
  logic             pkt_done;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // DRAIN is the cycle link_eop is shown; a flush in that cycle discards the packet.
  assign pkt_done = (state_q == StDrain) && !srst_g;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pkt_done && (grant_q == 2'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.pkt_cnt_0 = cnt_q[0];
  assign bus.pkt_cnt_1 = cnt_q[1];
  assign bus.pkt_cnt_2 = cnt_q[2];
`else
  assign bus.pkt_cnt_0 = CNT_W'(0);
  assign bus.pkt_cnt_1 = CNT_W'(0);
  assign bus.pkt_cnt_2 = CNT_W'(0);
`endif

endmodule

// File: tb/tb_router_out_sched.sv
// Scoreboard bench for router_out_sched: directed packets are loaded into behavioural FIFOs and
// their expected link bytes queued; a monitor compares every link_valid/link_abort cycle.
module tb_router_out_sched;

`ifdef ROUTER_SCHED_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic       abort;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  router_out_sched_if #(.CNT_W(16)) bus ();

  router_out_sched #(.CNT_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q [$];
  logic [7:0] fq0 [$];
  logic [7:0] fq1 [$];
  logic [7:0] fq2 [$];
  int         rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] ecnt(input int v);
    return Stats ? 32'(v) : 32'd0;
  endfunction

  // Behavioural FIFOs: registered dout loaded by read_enb, vld_out updated each clock.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fq0.delete(); fq1.delete(); fq2.delete();
      bus.dout_0 <= 8'h00; bus.dout_1 <= 8'h00; bus.dout_2 <= 8'h00;
      bus.vld_out_0 <= 1'b0; bus.vld_out_1 <= 1'b0; bus.vld_out_2 <= 1'b0;
    end else begin
      if (bus.read_enb_0 && fq0.size() > 0) begin bus.dout_0 <= fq0.pop_front(); rd_cnt0++; end
      if (bus.read_enb_1 && fq1.size() > 0) begin bus.dout_1 <= fq1.pop_front(); rd_cnt1++; end
      if (bus.read_enb_2 && fq2.size() > 0) begin bus.dout_2 <= fq2.pop_front(); rd_cnt2++; end
      if (bus.soft_reset_0) fq0.delete();
      if (bus.soft_reset_1) fq1.delete();
      if (bus.soft_reset_2) fq2.delete();
      bus.vld_out_0 <= fq0.size() != 0;
      bus.vld_out_1 <= fq1.size() != 0;
      bus.vld_out_2 <= fq2.size() != 0;
    end
  end

  // Monitor: every link output event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    logic [2:0] re;
    logic [2:0] re_want;
    #1;
    if (resetn) begin
      got = '{valid: bus.link_valid, abort: bus.link_abort, sop: bus.link_sop,
              eop: bus.link_eop, data: bus.link_data};
      if (bus.link_valid || bus.link_abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_link_event", 32'(got), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("link_byte", 32'(got), 32'(e));
        end
      end
      re = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
      if (re != 3'b000) begin
        re_want = (bus.grant == 2'd0) ? 3'b001 : (bus.grant == 2'd1) ? 3'b010 :
                  (bus.grant == 2'd2) ? 3'b100 : 3'b000;
        chk("read_enb_only_granted", 32'(re), 32'(re_want));
      end
    end
  end

  // Loads a packet of payload length len into FIFO port; queues the first n_exp link bytes
  // (all when negative) and optionally a trailing abort event.
  task automatic load_pkt(input int port, input int len, input int n_exp, input bit abort_exp);
    logic [7:0] b [$];
    logic [7:0] par;
    logic [5:0] l6;
    logic [1:0] p2;
    int total;
    l6 = 6'(len);
    p2 = 2'(port);
    b.push_back({l6, p2});
    for (int i = 0; i < len; i++) b.push_back(8'(port * 37 + i * 13 + len + 5));
    par = 8'h00;
    foreach (b[i]) par ^= b[i];
    b.push_back(par);
    total = b.size();
    for (int i = 0; i < total; i++) begin
      if (n_exp < 0 || i < n_exp)
        exp_q.push_back('{valid: 1'b1, abort: 1'b0, sop: (i == 0), eop: (i == total - 1),
                          data: b[i]});
    end
    if (abort_exp) exp_q.push_back('{valid: 1'b0, abort: 1'b1, sop: 1'b0, eop: 1'b0, data: 8'h00});
    foreach (b[i]) begin
      case (port)
        0:       fq0.push_back(b[i]);
        1:       fq1.push_back(b[i]);
        default: fq2.push_back(b[i]);
      endcase
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.grant != 2'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] want);
    int n = 0;
    while (bus.grant == 2'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.grant), 32'(want));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd3);
    chk({tag, "_read_enb"}, 32'({bus.read_enb_2, bus.read_enb_1, bus.read_enb_0}), 32'd0);
    chk({tag, "_link_flags"},
        32'({bus.link_valid, bus.link_sop, bus.link_eop, bus.link_abort}), 32'd0);
    chk({tag, "_link_data"}, 32'(bus.link_data), 32'd0);
    chk({tag, "_pkt_cnt"}, 32'(bus.pkt_cnt_0 | bus.pkt_cnt_1 | bus.pkt_cnt_2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    int k;
    bit busy;
    bus.soft_reset_0 = 1'b0;
    bus.soft_reset_1 = 1'b0;
    bus.soft_reset_2 = 1'b0;
    bus.link_ready   = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Port 1, L=3.
    load_pkt(1, 3, -1, 1'b0);
    wait_grant("t2_grant", 2'd1);
    wait_idle("t2_drain");
    chk("t2_pkt_cnt_1", 32'(bus.pkt_cnt_1), ecnt(1));

    // All ports at once after reset: order 0, 1, 2, 0.
    do_reset();
    load_pkt(0, 2, -1, 1'b0);
    load_pkt(1, 1, -1, 1'b0);
    load_pkt(2, 4, -1, 1'b0);
    load_pkt(0, 0, -1, 1'b0);
    wait_grant("t3_first_grant", 2'd0);
    wait_idle("t3_drain");
    chk("t3_pkt_cnt_0", 32'(bus.pkt_cnt_0), ecnt(2));
    chk("t3_pkt_cnt_2", 32'(bus.pkt_cnt_2), ecnt(1));

    // L=0 on port 2: 2 reads, idle again 5 cycles after the request is seen.
    base = rd_cnt2;
    load_pkt(2, 0, -1, 1'b0);
    n = 0;
    while (!bus.vld_out_2 && n < 20) begin @(negedge clk); n++; end
    chk("t4_idle_at_request", 32'(bus.grant), 32'd3);
    k = 0;
    busy = 1'b0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (bus.grant != 2'd3) busy = 1'b1;
      else if (busy) break;
    end
    chk("t4_cycles_to_idle", 32'(k), 32'd5);
    chk("t4_reads", 32'(rd_cnt2 - base), 32'd2);
    wait_idle("t4_drain");

    // link_ready stall of 4 cycles mid-BODY, L=10 on port 0.
    base = rd_cnt0;
    load_pkt(0, 10, -1, 1'b0);
    n = 0;
    while (rd_cnt0 < base + 4 && n < 100) begin @(negedge clk); n++; end
    bus.link_ready = 1'b0;
    base = rd_cnt0;
    repeat (4) @(negedge clk);
    chk("t5_no_reads_in_stall", 32'(rd_cnt0 - base), 32'd0);
    bus.link_ready = 1'b1;
    wait_idle("t5_drain");
    chk("t5_pkt_cnt_0", 32'(bus.pkt_cnt_0), ecnt(3));

    // Soft reset of granted port 0 after 6 bytes; port 1 must follow.
    base = rd_cnt0;
    load_pkt(0, 20, 6, 1'b1);
    wait_grant("t6_grant0", 2'd0);
    load_pkt(1, 2, -1, 1'b0);
    n = 0;
    while (rd_cnt0 < base + 6 && n < 100) begin @(negedge clk); n++; end
    bus.soft_reset_0 = 1'b1;
    #1;
    chk("t6_read_enb_0_drop", 32'(bus.read_enb_0), 32'd0);
    @(negedge clk);
    bus.soft_reset_0 = 1'b0;
    wait_grant("t6_next_grant", 2'd1);
    wait_idle("t6_drain");
    chk("t6_pkt_cnt_0", 32'(bus.pkt_cnt_0), ecnt(3));
    chk("t6_pkt_cnt_1", 32'(bus.pkt_cnt_1), ecnt(2));

    // Async reset mid-BODY on port 2, then port 0 must win over port 2.
    base = rd_cnt2;
    load_pkt(2, 10, 3, 1'b0);
    n = 0;
    while (rd_cnt2 < base + 3 && n < 100) begin @(negedge clk); n++; end
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("t7_async");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("t7_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    load_pkt(0, 1, -1, 1'b0);
    load_pkt(2, 1, -1, 1'b0);
    wait_grant("t7_grant_after_reset", 2'd0);
    wait_idle("t7_drain");
    chk("t7_pkt_cnt_0", 32'(bus.pkt_cnt_0), ecnt(1));
    chk("t7_pkt_cnt_2", 32'(bus.pkt_cnt_2), ecnt(1));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
